// File: rtl/dsdac_multi.sv
// Multi-channel first-order delta-sigma DAC: one-frame hold buffer, sample-rate divider, soft-mute gain ramp.
// Optional macro DSDAC_DITHER_EN adds one bit of LFSR dither to each channel's modulator input.
module dsdac_multi #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 2,
    parameter int RATE_DIV  = 256,
    parameter int GAIN_BITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      silent,
    output logic [CHANNELS-1:0]       analog,
    output logic                      muted,
    output logic                      underrun,
    output logic                      tick
);
    localparam int CW = $clog2(RATE_DIV);
    localparam int GW = GAIN_BITS + 1;
    localparam int PW = WIDTH + GAIN_BITS + 1;
    localparam int SW = WIDTH + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(RATE_DIV - 2);
    localparam logic [GW-1:0] GAIN_MAX = {1'b1, {GAIN_BITS{1'b0}}};

    typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;

    logic [CW-1:0]             cnt;
    logic                      hold_full;
    logic [CHANNELS*WIDTH-1:0] hold;
    logic [CHANNELS*WIDTH-1:0] active;
    state_t                    state, state_nx;
    logic [GW-1:0]             gain, gain_nx;

    // tick is registered one count early so it is high exactly while cnt == RATE_DIV-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            tick <= (cnt == CNT_PRE);
        end
    end

    // Handshake: a frame transfers on any rising edge where sample_valid && sample_ready;
    // sample_ready is the registered "hold empty" flag and never depends on sample_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold      <= '0;
            active    <= '0;
        end else if (tick && hold_full) begin
            active    <= hold;
            hold_full <= 1'b0;
        end else if (sample_valid && !hold_full) begin
            hold      <= sample_data;
            hold_full <= 1'b1;
        end
    end

    assign sample_ready = ~hold_full;
    assign underrun     = tick & ~hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MUTED;
            gain  <= '0;
        end else begin
            state <= state_nx;
            gain  <= gain_nx;
        end
    end

    // Direction follows silent on every clock; the gain itself only moves on ticks.
    always_comb begin
        state_nx = state;
        gain_nx  = gain;
        case (state)
            MUTED: begin
                if (!silent) state_nx = RAMP_UP;
            end
            RAMP_UP: begin
                if (silent) begin
                    state_nx = RAMP_DOWN;
                end else if (gain == GAIN_MAX) begin
                    state_nx = PLAY;
                end else if (tick) begin
                    gain_nx = gain + GW'(1);
                    if (gain_nx == GAIN_MAX) state_nx = PLAY;
                end
            end
            PLAY: begin
                if (silent) state_nx = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!silent) begin
                    state_nx = RAMP_UP;
                end else if (gain == '0) begin
                    state_nx = MUTED;
                end else if (tick) begin
                    gain_nx = gain - GW'(1);
                    if (gain_nx == '0) state_nx = MUTED;
                end
            end
            default: begin
                state_nx = MUTED;
                gain_nx  = '0;
            end
        endcase
    end

    assign muted = (state == MUTED);

`ifdef DSDAC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr <= 16'hACE1;
        else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [WIDTH-1:0] s;
        logic signed [PW-1:0]    prod;
        logic [WIDTH-1:0]        scaled;
        logic [WIDTH-1:0]        u;
        logic [WIDTH-1:0]        u_eff;
        logic [SW-1:0]           sigma;
        logic [SW-1:0]           fb;

        assign s      = active[k*WIDTH +: WIDTH];
        assign prod   = $signed({{(PW-WIDTH){s[WIDTH-1]}}, s}) * $signed({{(PW-GW){1'b0}}, gain});
        assign scaled = WIDTH'(prod >>> GAIN_BITS);
        // adding 2^(WIDTH-1) modulo 2^WIDTH is an MSB flip
        assign u      = {~scaled[WIDTH-1], scaled[WIDTH-2:0]};

`ifdef DSDAC_DITHER_EN
        logic [WIDTH:0] u_sum;
        assign u_sum = {1'b0, u} + (WIDTH+1)'(lfsr[0] ^ lfsr[8 + (k % 8)]);
        assign u_eff = u_sum[WIDTH] ? {WIDTH{1'b1}} : u_sum[WIDTH-1:0];
`else
        assign u_eff = u;
`endif

        assign fb = {sigma[SW-1], sigma[SW-1], {WIDTH{1'b0}}};

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sigma <= {2'b01, {WIDTH{1'b0}}};
            else          sigma <= sigma + {2'b00, u_eff} + fb;
        end

        assign analog[k] = sigma[SW-1];
    end

endmodule
